// File: rtl/sat_bm_pkg.sv
// sat_bm_pkg: shared arbiter state encoding and bin-manager requester indices
package sat_bm_pkg;
  typedef enum logic [1:0] {ARB = 2'd0, OWN = 2'd1, DRAIN = 2'd2} state_e;
  localparam int REQ_LOAD   = 0;
  localparam int REQ_UPDATE = 1;
  localparam int REQ_BKT    = 2;
  localparam int REQ_FIND   = 3;
endpackage

// File: rtl/arb_bin_mem_if.sv
// arb_bin_mem_if: requester-side bus and bin memory port of the bin memory arbiter
interface arb_bin_mem_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_ADDR = 10,
  parameter int WIDTH_DATA = 32
);
  logic [NUM_REQ-1:0]            req_i, en_i, we_i, gnt_o, rvalid_o;
  logic [NUM_REQ*WIDTH_ADDR-1:0] addr_i;
  logic [NUM_REQ*WIDTH_DATA-1:0] wdata_i;
  logic [WIDTH_DATA-1:0]         rdata_o, mem_wdata_o, mem_rdata_i;
  logic [WIDTH_ADDR-1:0]         mem_addr_o;
  logic                          mem_en_o, mem_we_o;
  modport slave (
    input  req_i, en_i, we_i, addr_i, wdata_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output req_i, en_i, we_i, addr_i, wdata_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/arb_bin_mem_rr_pick.sv
// rr_pick: circular priority picker, first set request at or after ptr_i wins
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] oh_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % N]) idx_o = W'((int'(ptr_i) + i) % N);
    any_o = |req_i;
    oh_o  = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/arb_bin_mem.sv
// arb_bin_mem: round-robin ownership arbiter for the shared single-port bin memory
module arb_bin_mem
  import sat_bm_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int WIDTH_ADDR = 10,
  parameter  int WIDTH_DATA = 32,
  parameter  int WIDTH_HOLD = 16,
  parameter  int MAX_HOLD   = 1024,
  localparam int OW         = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic          clk,
  input  logic          rst,
  arb_bin_mem_if.slave  bus,
  output logic          busy_o,
  output logic [OW-1:0] owner_o,
  output logic          hold_timeout_o
);
  state_e                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d, ptr_q, ptr_d, rd_owner_q, pick_idx;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d, pick_oh;
  logic [WIDTH_HOLD-1:0] hold_q, hold_d;
  logic                  pick_any, mem_en, rd_q, to_q, others;
  rr_pick #(.N(NUM_REQ), .W(OW)) u_pick (
    .req_i(bus.req_i), .ptr_i(ptr_q), .oh_o(pick_oh), .idx_o(pick_idx), .any_o(pick_any)
  );
  // Gating by the registered grant makes the port go quiet the instant reset asserts
  assign mem_en          = gnt_q[owner_q] & bus.en_i[owner_q] & bus.req_i[owner_q];
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_en & bus.we_i[owner_q];
  assign bus.mem_addr_o  = bus.addr_i[owner_q*WIDTH_ADDR +: WIDTH_ADDR];
  assign bus.mem_wdata_o = bus.wdata_i[owner_q*WIDTH_DATA +: WIDTH_DATA];
  assign bus.gnt_o       = gnt_q;
  assign bus.rvalid_o    = rd_q ? NUM_REQ'(1) << rd_owner_q : '0;
  assign bus.rdata_o     = bus.mem_rdata_i;
  assign busy_o          = state_q != ARB;
  assign owner_o         = owner_q;
  assign hold_timeout_o  = to_q;
  assign others          = |(bus.req_i & ~(NUM_REQ'(1) << owner_q));
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB: if (pick_any) begin
        state_d = OWN;
        owner_d = pick_idx;
        gnt_d   = pick_oh;
      end
      OWN: if (!bus.req_i[owner_q]) begin
        state_d = DRAIN;
        gnt_d   = '0;
        ptr_d   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = ARB;
    endcase
    hold_d = (state_q != OWN) ? '0 :
             (hold_q == WIDTH_HOLD'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      owner_q    <= '0;
      gnt_q      <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      to_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      to_q       <= to_q | ((hold_q == WIDTH_HOLD'(MAX_HOLD)) & others);
      rd_q       <= mem_en & ~bus.mem_we_o;
      rd_owner_q <= owner_q;
    end
  end
endmodule

// File: tb/tb_arb_bin_mem.sv
// tb_arb_bin_mem: directed checks of grant order, port muxing, read steering, timeout and reset
module tb_arb_bin_mem;
  localparam int N = 4, AW = 10, DW = 32;
  logic clk = 1'b0, rst = 1'b0;
  logic busy, to;
  logic [1:0] owner;
  logic [DW-1:0] mem [1024];
  int n_chk = 0, n_fail = 0;
  int order [5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;
  arb_bin_mem_if #(.NUM_REQ(N), .WIDTH_ADDR(AW), .WIDTH_DATA(DW)) bus ();
  arb_bin_mem #(.NUM_REQ(N), .WIDTH_ADDR(AW), .WIDTH_DATA(DW), .WIDTH_HOLD(16), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .owner_o(owner), .hold_timeout_o(to)
  );
  always @(posedge clk)
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      else bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input int k, input logic e, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.en_i[k] = e;
    bus.we_i[k] = w;
    bus.addr_i[k*AW +: AW] = a;
    bus.wdata_i[k*DW +: DW] = d;
  endtask
  initial begin
    logic [3:0] oh;
    bus.req_i = '0; bus.en_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 32'hA5;
    mem[3] = 32'h33;
    #3;
    check("rst_gnt", bus.gnt_o, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 2'd0);
    check("rst_to", to, 1'b0);
    check("rst_mem_en", bus.mem_en_o, 1'b0);
    check("rst_rvalid", bus.rvalid_o, 4'b0000);
    step;
    rst = 1'b1;
    bus.req_i = 4'b0001;
    step;
    check("single_gnt", bus.gnt_o, 4'b0001);
    check("single_busy", busy, 1'b1);
    step;
    drive(0, 1, 0, 10'd5, '0);
    #1;
    check("single_mem_en", bus.mem_en_o, 1'b1);
    check("single_mem_we", bus.mem_we_o, 1'b0);
    check("single_addr", bus.mem_addr_o, 10'd5);
    step;
    drive(0, 0, 0, '0, '0);
    check("single_rvalid", bus.rvalid_o, 4'b0001);
    check("single_rdata", bus.rdata_o, 32'hA5);
    bus.req_i = 4'b0000;
    step;
    check("single_drain_gnt", bus.gnt_o, 4'b0000);
    check("single_drain_busy", busy, 1'b1);
    step;
    check("single_arb_busy", busy, 1'b0);
    rst = 1'b0;
    step;
    rst = 1'b1;
    bus.req_i = 4'hF;
    step;
    for (int i = 0; i < 5; i++) begin
      oh = 4'(1 << order[i]);
      check($sformatf("rr_gnt%0d", i), bus.gnt_o, oh);
      drive(order[i], 1, 1, AW'(16 + order[i]), DW'(32'h100 + order[i]));
      #1;
      check($sformatf("rr_addr%0d", i), bus.mem_addr_o, 10'(16 + order[i]));
      step;
      drive(order[i], 0, 0, '0, '0);
      bus.req_i[order[i]] = 1'b0;
      check($sformatf("rr_rel_gnt%0d", i), bus.gnt_o, oh);
      step;
      check($sformatf("rr_drain%0d", i), {busy, bus.gnt_o}, 5'b10000);
      bus.req_i = (i == 4) ? 4'h0 : 4'hF;
      step;
      check($sformatf("rr_arb%0d", i), {busy, bus.gnt_o}, 5'b00000);
      step;
    end
    check("rr_mem16", mem[16], 32'h100);
    check("rr_mem19", mem[19], 32'h103);
    bus.req_i = 4'b0100;
    step;
    check("wr_gnt", bus.gnt_o, 4'b0100);
    drive(2, 1, 1, 10'd9, 32'h1234);
    drive(1, 1, 1, 10'd3, 32'hDEAD);
    bus.req_i[1] = 1'b1;
    #1;
    check("wr_addr", bus.mem_addr_o, 10'd9);
    check("wr_we", bus.mem_we_o, 1'b1);
    check("wr_wdata", bus.mem_wdata_o, 32'h1234);
    step;
    check("wr_mem9", mem[9], 32'h1234);
    check("wr_mem3", mem[3], 32'h33);
    drive(2, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    bus.req_i = 4'b0010;
    step;
    step;
    step;
    check("last_gnt", bus.gnt_o, 4'b0010);
    drive(1, 1, 0, 10'd3, '0);
    #1;
    check("last_mem_en", bus.mem_en_o, 1'b1);
    step;
    drive(1, 0, 0, '0, '0);
    bus.req_i = 4'b0000;
    check("last_rvalid", bus.rvalid_o, 4'b0010);
    check("last_rdata", bus.rdata_o, 32'h33);
    step;
    check("last_drain_gnt", bus.gnt_o, 4'b0000);
    check("last_drain_rvalid", bus.rvalid_o, 4'b0000);
    step;
    bus.req_i = 4'b0001;
    step;
    check("to_gnt", bus.gnt_o, 4'b0001);
    bus.req_i = 4'b1001;
    for (int k = 1; k <= 10; k++) begin
      if (k == 9) check("to_before", to, 1'b0);
      if (k == 10) check("to_set", to, 1'b1);
      step;
    end
    bus.req_i[0] = 1'b0;
    step;
    check("to_sticky_drain", to, 1'b1);
    step;
    step;
    check("to_next_gnt", bus.gnt_o, 4'b1000);
    check("to_next_owner", owner, 2'd3);
    check("to_sticky", to, 1'b1);
    drive(3, 1, 0, 10'd5, '0);
    #1;
    check("rst_mid_mem_en", bus.mem_en_o, 1'b1);
    step;
    check("rst_mid_rvalid", bus.rvalid_o, 4'b1000);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_gnt", bus.gnt_o, 4'b0000);
    check("rst_async_mem_en", bus.mem_en_o, 1'b0);
    check("rst_async_rvalid", bus.rvalid_o, 4'b0000);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_to", to, 1'b0);
    drive(3, 0, 0, '0, '0);
    bus.req_i = 4'b0000;
    #1;
    rst = 1'b1;
    bus.req_i = 4'b0100;
    step;
    check("post_rst_gnt", bus.gnt_o, 4'b0100);
    check("post_rst_owner", owner, 2'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
